// File: rtl/seg_hex_multi_if.sv
// Bundle of the data, mask and display signals of the multi-digit hex driver.
// The master drives value/masks and observes the segment/anode outputs.
interface seg_hex_multi_if #(
    parameter int NDIG = 8
);
    logic              load;
    logic [4*NDIG-1:0] din;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   en_mask;
    logic              lz_blank;
    logic [NDIG-1:0]   blink_mask;
    logic [8*NDIG-1:0] o_seg;
    logic [7:0]        o_scan_seg;
    logic [NDIG-1:0]   o_an;

    modport master (
        output load, din, dp_in, en_mask, lz_blank, blink_mask,
        input  o_seg, o_scan_seg, o_an
    );

    modport slave (
        input  load, din, dp_in, en_mask, lz_blank, blink_mask,
        output o_seg, o_scan_seg, o_an
    );
endinterface

// File: rtl/seg_hex_multi.sv
// Multi-digit hex 7-segment driver: static per-digit outputs plus a
// time-multiplexed scan output, with enable, blink and leading-zero blanking.
module seg_hex_multi #(
    parameter int NDIG    = 8,
    parameter int SCAN_W  = 16,
    parameter int BLINK_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    seg_hex_multi_if.slave  bus
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [8*NDIG-1:0] o_seg_q, o_seg_d;
    logic [7:0]        o_scan_seg_q, o_scan_seg_d;
    logic [NDIG-1:0]   o_an_q, o_an_d;
    logic [NDIG-1:0]   lz_dark;
    logic              seen_nz;

    // Active-high a..g pattern in bits [7:1]; bit 0 (dp) left clear.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 8'hFC;
            4'h1: hex_to_seg = 8'h60;
            4'h2: hex_to_seg = 8'hDA;
            4'h3: hex_to_seg = 8'hF2;
            4'h4: hex_to_seg = 8'h66;
            4'h5: hex_to_seg = 8'hB6;
            4'h6: hex_to_seg = 8'hBE;
            4'h7: hex_to_seg = 8'hE0;
            4'h8: hex_to_seg = 8'hFE;
            4'h9: hex_to_seg = 8'hF6;
            4'hA: hex_to_seg = 8'hEE;
            4'hB: hex_to_seg = 8'h3E;
            4'hC: hex_to_seg = 8'h9C;
            4'hD: hex_to_seg = 8'h7A;
            4'hE: hex_to_seg = 8'h9E;
            4'hF: hex_to_seg = 8'h8E;
            default: hex_to_seg = 8'h00;
        endcase
    endfunction

    // Walk down from the top digit; a digit is a leading zero until a nonzero one is seen.
    always_comb begin
        lz_dark = '0;
        seen_nz = 1'b0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (value_q[4*i +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            lz_dark[i] = bus.lz_blank & ~seen_nz;
        end
    end

    always_comb begin
        value_d     = bus.load ? bus.din : value_q;
        dp_d        = bus.load ? bus.dp_in : dp_q;
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        scan_idx_d  = scan_idx_q;
        if (scan_cnt_q == '1) begin
            scan_idx_d = (scan_idx_q == IDX_W'(NDIG - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end

        o_seg_d = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (!bus.en_mask[i]) begin
                o_seg_d[8*i +: 8] = 8'hFF;
            end else if (bus.blink_mask[i] && blink_cnt_q[BLINK_W-1]) begin
                o_seg_d[8*i +: 8] = 8'hFF;
            end else if (lz_dark[i]) begin
                o_seg_d[8*i +: 8] = ~{7'b0, dp_q[i]};
            end else begin
                o_seg_d[8*i +: 8] = ~(hex_to_seg(value_q[4*i +: 4]) | {7'b0, dp_q[i]});
            end
        end

        // Scan output is taken from the same next-state pattern so it lines up with o_an.
        o_scan_seg_d = 8'hFF;
        o_an_d       = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (IDX_W'(i) == scan_idx_q) begin
                o_scan_seg_d = o_seg_d[8*i +: 8];
                o_an_d[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q      <= '0;
            dp_q         <= '0;
            blink_cnt_q  <= '0;
            scan_cnt_q   <= '0;
            scan_idx_q   <= '0;
            o_seg_q      <= '1;
            o_scan_seg_q <= 8'hFF;
            o_an_q       <= '1;
        end else begin
            value_q      <= value_d;
            dp_q         <= dp_d;
            blink_cnt_q  <= blink_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            o_seg_q      <= o_seg_d;
            o_scan_seg_q <= o_scan_seg_d;
            o_an_q       <= o_an_d;
        end
    end

    assign bus.o_seg      = o_seg_q;
    assign bus.o_scan_seg = o_scan_seg_q;
    assign bus.o_an       = o_an_q;
endmodule

// File: tb/tb_seg_hex_multi.sv
// Scoreboard bench for seg_hex_multi: NDIG=4 main instance plus an NDIG=3
// instance for the non-power-of-two scan wrap.
module tb_seg_hex_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct packed {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [31:0] mon_act;

    logic [3:0]  an_seq  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [7:0]  dig_seq [5] = '{8'h71, 8'h0D, 8'h10, 8'h9F, 8'h71};
    logic [2:0]  an3_seq [4] = '{3'b110, 3'b101, 3'b011, 3'b110};

    seg_hex_multi_if #(.NDIG(4)) bus();
    seg_hex_multi_if #(.NDIG(3)) bus3();

    seg_hex_multi #(.NDIG(4), .SCAN_W(2), .BLINK_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seg_hex_multi #(.NDIG(3), .SCAN_W(2), .BLINK_W(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            0: kind_name = "o_seg";
            1: kind_name = "o_an";
            2: kind_name = "o_scan_seg";
            3: kind_name = "o_an(NDIG=3)";
            default: kind_name = "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            0: actual = bus.o_seg;
            1: actual = {28'b0, bus.o_an};
            2: actual = {24'b0, bus.o_scan_seg};
            3: actual = {29'b0, bus3.o_an};
            default: actual = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Expected responses are queued against the cycle at which they must appear.
    task automatic checkOutput(input int at, input int kind, input logic [31:0] exp);
        sb_item_t item;
        item.cyc  = at;
        item.kind = kind;
        item.exp  = exp;
        sb_q.push_back(item);
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d,
                                 input logic [3:0] dp, input logic [3:0] en,
                                 input logic lz, input logic [3:0] blink);
        rst            = r;
        bus.load       = ld;
        bus.din        = d;
        bus.dp_in      = dp;
        bus.en_mask    = en;
        bus.lz_blank   = lz;
        bus.blink_mask = blink;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: on every falling edge, compare and retire the entries due now.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                mon_act = actual(sb_q[i].kind);
                n_tests++;
                if (mon_act !== sb_q[i].exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s @cycle %0d: got %h, expected %h",
                             kind_name(sb_q[i].kind), cyc, mon_act, sb_q[i].exp);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        bus3.load       = 1'b0;
        bus3.din        = '0;
        bus3.dp_in      = '0;
        bus3.en_mask    = 3'b111;
        bus3.lz_blank   = 1'b0;
        bus3.blink_mask = '0;

        applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 4'b0000);
        checkOutput(1, 0, 32'hFFFF_FFFF);
        checkOutput(1, 1, 32'h0000_000F);
        checkOutput(1, 2, 32'h0000_00FF);
        checkOutput(1, 3, 32'h0000_0007);
        checkOutput(2, 0, 32'h0303_0303);
        checkOutput(3, 0, 32'h9F10_0D71);
        for (int c = 2; c <= 21; c++) begin
            checkOutput(c, 1, {28'b0, an_seq[(c - 2) / 4]});
            checkOutput(c, 2, {24'b0, (c == 2) ? 8'h03 : dig_seq[(c - 2) / 4]});
        end
        for (int c = 2; c <= 17; c++) begin
            checkOutput(c, 3, {29'b0, an3_seq[(c - 2) / 4]});
        end

        waitCyc(1);
        n_tests++;
        if (bus.o_seg !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL direct o_seg after reset: got %h", bus.o_seg);
        end
        n_tests++;
        if (bus.o_an !== 4'b1111) begin
            n_fail++;
            $display("[TB] FAIL direct o_an after reset: got %b", bus.o_an);
        end
        applyStimulus(1'b0, 1'b1, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 4'b0000);
        waitCyc(2);
        n_tests++;
        if (bus.o_seg !== 32'h0303_0303) begin
            n_fail++;
            $display("[TB] FAIL direct o_seg first edge after reset: got %h", bus.o_seg);
        end
        applyStimulus(1'b0, 1'b0, 16'h1A3F, 4'b0100, 4'hF, 1'b0, 4'b0000);

        waitCyc(21);
        checkOutput(22, 0, 32'h9F10_0D71);
        checkOutput(23, 0, 32'hFFFF_4903);
        checkOutput(24, 0, 32'hFFFF_FF03);
        applyStimulus(1'b0, 1'b1, 16'h0050, 4'b0000, 4'hF, 1'b1, 4'b0000);
        waitCyc(22);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 4'hF, 1'b1, 4'b0000);
        waitCyc(23);
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'hF, 1'b1, 4'b0000);
        waitCyc(24);
        checkOutput(25, 0, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b1110, 1'b1, 4'b0000);
        waitCyc(25);
        checkOutput(26, 0, 32'h0303_03FF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b1110, 1'b0, 4'b0000);

        waitCyc(26);
        checkOutput(27, 0, 32'h0303_0303);
        checkOutput(28, 0, 32'h9E24_0C98);
        checkOutput(29, 0, 32'hC163_8561);
        checkOutput(30, 0, 32'hC163_8561);
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b1111, 4'hF, 1'b0, 4'b0000);
        waitCyc(27);
        applyStimulus(1'b0, 1'b1, 16'hBCDE, 4'b0000, 4'hF, 1'b0, 4'b0000);
        waitCyc(28);
        applyStimulus(1'b0, 1'b0, 16'h5555, 4'b1111, 4'hF, 1'b0, 4'b0000);
        waitCyc(30);
        checkOutput(32, 0, 32'h411F_0109);
        applyStimulus(1'b0, 1'b1, 16'h6789, 4'b0000, 4'hF, 1'b0, 4'b0000);
        waitCyc(31);
        applyStimulus(1'b0, 1'b0, 16'h6789, 4'b0000, 4'hF, 1'b0, 4'b0000);

        waitCyc(43);
        n_tests++;
        if (bus.o_an !== 4'b1011) begin
            n_fail++;
            $display("[TB] FAIL direct o_an mid-scan: got %b", bus.o_an);
        end
        checkOutput(43, 1, 32'h0000_000B);
        checkOutput(44, 0, 32'hFFFF_FFFF);
        checkOutput(44, 1, 32'h0000_000F);
        checkOutput(44, 2, 32'h0000_00FF);
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'b1111, 4'hF, 1'b0, 4'b0000);

        waitCyc(44);
        n_tests++;
        if (bus.o_seg !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL direct o_seg after mid-scan reset: got %h", bus.o_seg);
        end
        n_tests++;
        if (bus.o_an !== 4'b1111) begin
            n_fail++;
            $display("[TB] FAIL direct o_an after mid-scan reset: got %b", bus.o_an);
        end
        for (int c = 45; c <= 60; c++) begin
            checkOutput(c, 0, (((c - 45) / 4) % 2 == 1) ? 32'h0303_03FF : 32'h0303_0303);
        end
        for (int c = 45; c <= 52; c++) begin
            checkOutput(c, 1, (c <= 48) ? 32'h0000_000E : 32'h0000_000D);
        end
        checkOutput(45, 2, 32'h0000_0003);
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'hF, 1'b0, 4'b0001);

        waitCyc(60);
        checkOutput(61, 0, 32'hFFFF_FF03);
        checkOutput(62, 0, 32'hFE0D_0349);
        checkOutput(65, 0, 32'hFE0D_FF49);
        applyStimulus(1'b0, 1'b1, 16'h0305, 4'b1000, 4'hF, 1'b1, 4'b0010);
        waitCyc(61);
        applyStimulus(1'b0, 1'b0, 16'h0305, 4'b1000, 4'hF, 1'b1, 4'b0010);
        waitCyc(65);
        checkOutput(66, 0, 32'hFF0D_FF49);
        checkOutput(69, 0, 32'hFF0D_0349);
        applyStimulus(1'b0, 1'b0, 16'h0305, 4'b1000, 4'b0111, 1'b1, 4'b0010);

        waitCyc(72);
        foreach (sb_q[i]) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s @cycle %0d: never compared, expected %h",
                     kind_name(sb_q[i].kind), sb_q[i].cyc, sb_q[i].exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
